// File: rtl/mod_red_final_pkg.sv
// Shared definitions for the final modular reduction stage.
// No ports: provides parameter defaults, the correction-select encoding
// and a width helper for counters that must hold 0..N inclusive.
`include "defines.v"

package mod_red_final_pkg;

  localparam int MRF_DEF_DATA_SIZE  = `DATA_SIZE_ARB;
  localparam int MRF_DEF_PIPE_DEPTH = 4;
  localparam int MRF_DEF_FIFO_DEPTH = `MRF_FIFO_DEPTH;

  // Which candidate the correction picks: x, x-q or x-2q.
  typedef enum logic [1:0] {
    CORR_PASS   = 2'd0,
    CORR_SUB_Q  = 2'd1,
    CORR_SUB_2Q = 2'd2
  } corr_sel_e;

  // Bits needed for a counter spanning 0..n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/defines.v
// Project-wide width defaults shared by the modular reduction pipeline.
//   DATA_SIZE_ARB  : modulus / result width
//   W_SIZE         : machine word width of the surrounding datapath
//   MRF_FIFO_DEPTH : default output FIFO depth of mod_red_final
`ifndef MRF_DEFINES_V
`define MRF_DEFINES_V
`define DATA_SIZE_ARB 16
`define W_SIZE 32
`define MRF_FIFO_DEPTH 8
`endif

// File: rtl/mrf_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports:
//   clk, reset (synchronous, active-low)
//   push, push_data   : write request / data
//   pop               : read request (ignored when empty)
//   pop_data          : head entry, zero while empty
//   count, full, empty: occupancy status
module mrf_fifo
  import mod_red_final_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WIDTH-1:0]            push_data,
  input  logic                        pop,
  output logic [WIDTH-1:0]            pop_data,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic             do_push, do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Gated to zero while empty so the head never shows stale RAM contents.
  assign pop_data = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/mod_red_final.sv
// Final modular reduction stage: folds a chain result in [0, 3q) into
// [0, q) with two conditional subtractions, re-attaches the valid tag
// tracked alongside the fixed-latency chain, and buffers results in an
// output FIFO protected by credit-based issue backpressure.
// Ports:
//   clk, reset               : clock, synchronous active-low reset
//   q                        : modulus (quasi-static)
//   issue_valid/issue_ready  : operand issue handshake at chain entry
//   chain_data               : last reduction stage output
//   out_data/out_valid/out_ready : result stream (FIFO head)
//   range_err                : sticky, a corrected value was still >= q
module mod_red_final
  import mod_red_final_pkg::*;
#(
  parameter int DATA_SIZE  = MRF_DEF_DATA_SIZE,
  parameter int IN_WIDTH   = DATA_SIZE + 2,
  parameter int PIPE_DEPTH = MRF_DEF_PIPE_DEPTH,
  parameter int FIFO_DEPTH = MRF_DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_SIZE-1:0] q,
  input  logic                 issue_valid,
  output logic                 issue_ready,
  input  logic [IN_WIDTH-1:0]  chain_data,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 range_err
);

  // One extra bit so the MSB of x-q / x-2q acts as a sign bit.
  localparam int CW  = IN_WIDTH + 1;
  localparam int CRW = cnt_width(FIFO_DEPTH);

  logic                  issue_fire, pop_fire, tag_valid;
  logic [PIPE_DEPTH-1:0] vld_sr_reg, vld_sr_next;
  logic [CW-1:0]         x_ext, q_ext, d1, d2, r;
  corr_sel_e             sel;
  logic                  r_high;
  logic [DATA_SIZE-1:0]  corr_reg;
  logic                  corr_valid_reg, range_err_reg;
  logic [CRW-1:0]        credits_reg, credits_next;
  logic [CRW-1:0]        fifo_count;
  logic                  fifo_full, fifo_empty;

  assign issue_fire  = issue_valid & issue_ready;
  assign pop_fire    = out_valid & out_ready;
  assign issue_ready = (credits_reg < CRW'(FIFO_DEPTH));
  assign out_valid   = ~fifo_empty;
  assign range_err   = range_err_reg;
  assign tag_valid   = vld_sr_reg[PIPE_DEPTH-1];

  // Tag travels in lockstep with the operand through the chain.
  always_comb begin
    vld_sr_next    = '0;
    vld_sr_next[0] = issue_fire;
    for (int i = 1; i < PIPE_DEPTH; i++) begin
      vld_sr_next[i] = vld_sr_reg[i-1];
    end
  end

  assign x_ext = CW'(chain_data);
  assign q_ext = CW'(q);
  assign d1    = x_ext - q_ext;
  assign d2    = x_ext - (q_ext << 1);

  always_comb begin
    sel = CORR_PASS;
    if (!d2[CW-1]) begin
      sel = CORR_SUB_2Q;
    end else if (!d1[CW-1]) begin
      sel = CORR_SUB_Q;
    end
  end

  always_comb begin
    case (sel)
      CORR_SUB_2Q: r = d2;
      CORR_SUB_Q:  r = d1;
      default:     r = x_ext;
    endcase
  end

  // Only possible when the chain handed us something >= 3q.
  assign r_high = (r >= q_ext);

  always_comb begin
    credits_next = credits_reg;
    case ({issue_fire, pop_fire})
      2'b10:   credits_next = credits_reg + CRW'(1);
      2'b01:   credits_next = credits_reg - CRW'(1);
      default: credits_next = credits_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_sr_reg     <= '0;
      corr_reg       <= '0;
      corr_valid_reg <= 1'b0;
      range_err_reg  <= 1'b0;
      credits_reg    <= '0;
    end else begin
      vld_sr_reg     <= vld_sr_next;
      corr_valid_reg <= tag_valid;
      credits_reg    <= credits_next;
      if (tag_valid) begin
        corr_reg <= r[DATA_SIZE-1:0];
        if (r_high) range_err_reg <= 1'b1;
      end
    end
  end

  mrf_fifo #(
    .WIDTH (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (corr_valid_reg),
    .push_data (corr_reg),
    .pop       (pop_fire),
    .pop_data  (out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Credits reserve a slot for every in-flight result, so a push can
  // never find the FIFO full and occupancy never exceeds the credits.
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset)
    !(corr_valid_reg && fifo_full));
  a_credit_cover: assert property (@(posedge clk) disable iff (!reset)
    credits_reg >= fifo_count);

endmodule
